// File: rtl/sample_feeder_pkg.sv
// Shared types and constants for the sample feeder: state encoding,
// sample width and default address width.
package sample_feeder_pkg;

    localparam int SAMPLE_W   = 32;
    localparam int DEF_ADDR_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/sample_feeder_if.sv
// Bundle of acquisition-side and sequencer-side signals of the sample feeder.
// The slave modport is the feeder's view; master is the driving side.
interface sample_feeder_if
    import sample_feeder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic                wr_en;
    logic [SAMPLE_W-1:0] wr_data;
    logic                load_done;
    logic                filt_ready;
    logic                filt_inc;
    logic                filt_valid;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   end_addr;
    logic [SAMPLE_W-1:0] din;
    logic                start;
    logic                busy;
    logic                full;
    logic                overflow;
    logic                done;

    modport slave (
        input  wr_en, wr_data, load_done, filt_ready, filt_inc, filt_valid,
        output addr, end_addr, din, start, busy, full, overflow, done
    );

    modport master (
        output wr_en, wr_data, load_done, filt_ready, filt_inc, filt_valid,
        input  addr, end_addr, din, start, busy, full, overflow, done
    );

endinterface

// File: rtl/sample_ram.sv
// Simple-dual-port single-clock RAM with a registered read port.
// Read of the address being written returns the old word.
module sample_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array itself has no reset so it maps onto block RAM; only the read register clears.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else     rdata <= mem[raddr];
    end

endmodule

// File: rtl/sample_feeder.sv
// Buffers one block of samples, then feeds it to the filter sequencer:
// start handshake, address stepping on inc, completion on valid rising edge.
module sample_feeder
    import sample_feeder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic            clk,
    input  logic            rst,
    sample_feeder_if.slave  sf
);

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr, addr_next;
    logic [ADDR_W-1:0] end_addr, end_addr_next;
    logic [ADDR_W-1:0] wr_cnt, wr_cnt_next;
    logic [ADDR_W-1:0] last_addr;
    logic              overflow, overflow_next;
    logic              valid_q;
    logic              mem_we;
    logic              start, done, full;

    assign full      = (wr_cnt == ADDR_W'(DEPTH - 1));
    assign last_addr = end_addr - ADDR_W'(1);

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next    = state;
        addr_next     = addr;
        end_addr_next = end_addr;
        wr_cnt_next   = wr_cnt;
        overflow_next = overflow;
        mem_we        = 1'b0;
        start         = 1'b0;
        done          = 1'b0;

        // Writes are only accepted while loading; ARM/RUN silently drop them.
        if ((state == ST_IDLE || state == ST_LOAD) && sf.wr_en) begin
            if (full) begin
                overflow_next = 1'b1;
            end else begin
                mem_we      = 1'b1;
                wr_cnt_next = wr_cnt + ADDR_W'(1);
            end
        end

        unique case (state)
            ST_IDLE: begin
                if (sf.wr_en) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (sf.load_done) begin
                    end_addr_next = wr_cnt_next;
                    addr_next     = '0;
                    state_next    = ST_ARM;
                end
            end
            ST_ARM: begin
                if (sf.filt_ready) begin
                    start      = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (sf.filt_inc && addr < last_addr) addr_next = addr + ADDR_W'(1);
                if (sf.filt_valid && !valid_q) state_next = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                wr_cnt_next = '0;
                addr_next   = '0;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            addr     <= '0;
            end_addr <= '0;
            wr_cnt   <= '0;
            overflow <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_next;
            addr     <= addr_next;
            end_addr <= end_addr_next;
            wr_cnt   <= wr_cnt_next;
            overflow <= overflow_next;
            valid_q  <= sf.filt_valid;
        end
    end

    // Reading at addr_next keeps din aligned with addr in the cycle addr moves.
    sample_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (SAMPLE_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (wr_cnt),
        .wdata (sf.wr_data),
        .raddr (addr_next),
        .rdata (sf.din)
    );

    assign sf.addr     = addr;
    assign sf.end_addr = end_addr;
    assign sf.start    = start;
    assign sf.done     = done;
    assign sf.busy     = (state == ST_ARM) || (state == ST_RUN);
    assign sf.full     = full;
    assign sf.overflow = overflow;

endmodule

// File: tb/tb_sample_feeder.sv
// Scoreboard bench for sample_feeder: stimulus queues expected output events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_sample_feeder;
    import sample_feeder_pkg::*;

    localparam int AW = 10;

    typedef enum logic [2:0] {EV_START, EV_ADDR, EV_DONE, EV_FULL, EV_OVF} ev_kind_t;

    typedef struct {
        ev_kind_t    kind;
        logic [9:0]  addr;
        logic [31:0] din;
        logic [9:0]  end_addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    logic       mon_en = 1'b0;
    logic [9:0] prev_addr = '0;
    logic       prev_full = 1'b0;
    logic       prev_ovf  = 1'b0;

    sample_feeder_if #(.ADDR_W(AW)) ifc ();

    sample_feeder #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .sf  (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic void push(input ev_kind_t k, input logic [9:0] a,
                                 input logic [31:0] d, input logic [9:0] ea);
        exp_t e;
        e.kind = k; e.addr = a; e.din = d; e.end_addr = ea;
        sb.push_back(e);
    endfunction

    task automatic take_event(input ev_kind_t k);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got=%s want=none", k.name());
        end else begin
            e = sb.pop_front();
            check({"ev_kind_", e.kind.name()}, 32'(k), 32'(e.kind));
            case (k)
                EV_START: begin
                    check("start_addr", 32'(ifc.addr), 32'(e.addr));
                    check("start_din", ifc.din, e.din);
                    check("start_end_addr", 32'(ifc.end_addr), 32'(e.end_addr));
                    check("start_busy", 32'(ifc.busy), 32'd1);
                end
                EV_ADDR: begin
                    check("addr", 32'(ifc.addr), 32'(e.addr));
                    check("addr_din", ifc.din, e.din);
                end
                EV_DONE: begin
                    check("done_busy", 32'(ifc.busy), 32'd0);
                    check("done_end_addr", 32'(ifc.end_addr), 32'(e.end_addr));
                end
                EV_FULL: check("full_no_ovf", 32'(ifc.overflow), 32'd0);
                EV_OVF:  check("ovf_full", 32'(ifc.full), 32'd1);
                default: ;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (ifc.full && !prev_full)  take_event(EV_FULL);
            if (ifc.overflow && !prev_ovf) take_event(EV_OVF);
            if (ifc.addr != prev_addr)   take_event(EV_ADDR);
            if (ifc.start)               take_event(EV_START);
            if (ifc.done)                take_event(EV_DONE);
        end
        prev_addr = ifc.addr;
        prev_full = ifc.full;
        prev_ovf  = ifc.overflow;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [31:0] d);
        ifc.wr_en   = 1'b1;
        ifc.wr_data = d;
        tick();
        ifc.wr_en   = 1'b0;
    endtask

    task automatic pulse_load_done();
        ifc.load_done = 1'b1;
        tick();
        ifc.load_done = 1'b0;
    endtask

    task automatic inc_pulse();
        ifc.filt_inc = 1'b1;
        tick();
        ifc.filt_inc = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifc.wr_en      = 1'b0;
        ifc.wr_data    = '0;
        ifc.load_done  = 1'b0;
        ifc.filt_ready = 1'b0;
        ifc.filt_inc   = 1'b0;
        ifc.filt_valid = 1'b0;
        rst            = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        check("rst_addr", 32'(ifc.addr), 32'd0);
        check("rst_end_addr", 32'(ifc.end_addr), 32'd0);
        check("rst_din", ifc.din, 32'd0);
        check("rst_start", 32'(ifc.start), 32'd0);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_full", 32'(ifc.full), 32'd0);
        check("rst_overflow", 32'(ifc.overflow), 32'd0);
        check("rst_done", 32'(ifc.done), 32'd0);
        mon_en = 1'b1;

        // Block of four, valid left high from a previous block
        ifc.filt_ready = 1'b1;
        ifc.filt_valid = 1'b1;
        write(32'h11); write(32'h22); write(32'h33); write(32'h44);
        push(EV_START, 10'd0, 32'h11, 10'd4);
        pulse_load_done();
        tick();
        push(EV_ADDR, 10'd1, 32'h22, '0); inc_pulse(); tick(); tick();
        push(EV_ADDR, 10'd2, 32'h33, '0); inc_pulse(); tick(); tick();
        push(EV_ADDR, 10'd3, 32'h44, '0); inc_pulse(); tick(); tick();
        inc_pulse(); tick();
        check("sat_addr", 32'(ifc.addr), 32'd3);
        check("run_busy", 32'(ifc.busy), 32'd1);
        ifc.filt_valid = 1'b0;
        tick(); tick();
        push(EV_DONE, '0, '0, 10'd4);
        ifc.filt_valid = 1'b1;
        tick();
        push(EV_ADDR, 10'd0, 32'h11, '0);
        tick(); tick();
        check("blk1_state_idle", 32'(dut.state), 32'(ST_IDLE));
        check("blk1_wr_cnt", 32'(dut.wr_cnt), 32'd0);

        // load_done with nothing written is ignored
        pulse_load_done();
        tick();
        check("empty_ld_busy", 32'(ifc.busy), 32'd0);
        check("empty_ld_state", 32'(dut.state), 32'(ST_IDLE));

        // Write coinciding with load_done is counted
        write(32'hA0); write(32'hA1);
        push(EV_START, 10'd0, 32'hA0, 10'd3);
        ifc.wr_en = 1'b1; ifc.wr_data = 32'hA2; ifc.load_done = 1'b1;
        tick();
        ifc.wr_en = 1'b0; ifc.load_done = 1'b0;
        tick();
        push(EV_ADDR, 10'd1, 32'hA1, '0); inc_pulse(); tick();
        push(EV_ADDR, 10'd2, 32'hA2, '0); inc_pulse(); tick();
        ifc.filt_valid = 1'b0;
        tick();
        push(EV_DONE, '0, '0, 10'd3);
        ifc.filt_valid = 1'b1;
        tick();
        push(EV_ADDR, 10'd0, 32'hA0, '0);
        tick(); tick();

        // Fill to DEPTH-1 and overflow by one
        ifc.filt_ready = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            if (i == 1022) push(EV_FULL, '0, '0, '0);
            if (i == 1023) push(EV_OVF, '0, '0, '0);
            write(32'h1000 + i);
        end
        check("fill_full", 32'(ifc.full), 32'd1);
        check("fill_overflow", 32'(ifc.overflow), 32'd1);
        check("fill_wr_cnt", 32'(dut.wr_cnt), 32'd1023);
        pulse_load_done();
        tick();
        check("fill_end_addr", 32'(ifc.end_addr), 32'd1023);
        check("arm_wait_busy", 32'(ifc.busy), 32'd1);
        check("arm_wait_start", 32'(ifc.start), 32'd0);
        push(EV_START, 10'd0, 32'h1000, 10'd1023);
        ifc.filt_ready = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) begin
            push(EV_ADDR, 10'(k), 32'h1000 + k, '0);
            ifc.filt_inc = 1'b1;
            tick();
        end
        ifc.filt_inc = 1'b0;
        check("pre_rst_addr", 32'(ifc.addr), 32'd5);

        // Reset in RUN
        push(EV_ADDR, 10'd0, 32'd0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
        check("mid_rst_end_addr", 32'(ifc.end_addr), 32'd0);
        check("mid_rst_din", ifc.din, 32'd0);
        check("mid_rst_busy", 32'(ifc.busy), 32'd0);
        check("mid_rst_full", 32'(ifc.full), 32'd0);
        check("mid_rst_overflow", 32'(ifc.overflow), 32'd0);
        check("mid_rst_start_done", 32'({ifc.start, ifc.done}), 32'd0);

        // Fresh two-sample block after reset
        write(32'hB0); write(32'hB1);
        push(EV_START, 10'd0, 32'hB0, 10'd2);
        pulse_load_done();
        tick();
        push(EV_ADDR, 10'd1, 32'hB1, '0); inc_pulse(); tick();
        inc_pulse(); tick();
        check("blk4_sat_addr", 32'(ifc.addr), 32'd1);
        ifc.filt_valid = 1'b0;
        tick();
        push(EV_DONE, '0, '0, 10'd2);
        ifc.filt_valid = 1'b1;
        tick();
        push(EV_ADDR, 10'd0, 32'hB0, '0);
        tick(); tick();
        check("blk4_busy", 32'(ifc.busy), 32'd0);
        check("blk4_overflow", 32'(ifc.overflow), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
